// File: rtl/pk_link_pkg.sv
// Shared constants and state types for the pk_link host link.
package pk_link_pkg;

    // Command codes; FN and ROT are ranges matched on their upper bits
    localparam logic [7:0] CMD_FN     = 8'h00;
    localparam logic [7:0] CMD_ROT    = 8'h20;
    localparam logic [7:0] CMD_KEYS   = 8'h30;
    localparam logic [7:0] CMD_STATUS = 8'h31;
    localparam logic [3:0] FN_LIMIT   = 4'd12;

    localparam logic [1:0] RPT_HDR_B1 = 2'b11;
    localparam logic [1:0] RPT_HDR_B2 = 2'b10;

    typedef enum logic [1:0] {StIdle, StKeyHi, StKeyLo} rx_state_e;
    typedef enum logic [1:0] {StTxIdle, StTxB1, StTxB2} tx_state_e;

endpackage

// File: rtl/pk_link_if.sv
// UART byte-stream interface between the host UART (master) and pk_link (slave).
interface pk_link_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, output rx_valid, output tx_ready,
                    input tx_data, input tx_valid);
    modport slave  (input rx_data, input rx_valid, input tx_ready,
                    output tx_data, output tx_valid);
endinterface

// File: rtl/pk_link_tx.sv
// Report serializer: snapshots panel state, sends a 2-byte report, collapses
// overlapping requests into one pending follow-up report.
module pk_link_tx
    import pk_link_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       req,
    input  logic [9:0] indicators,
    input  logic [3:0] rotary_pos,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    tx_state_e  state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] b1_q, b1_d, b2_q, b2_d;
    logic       start;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StTxIdle;
            pending_q <= 1'b0;
            b1_q      <= '0;
            b2_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        start     = 1'b0;
        case (state_q)
            StTxIdle: start = req;
            StTxB1: begin
                if (req) pending_d = 1'b1;
                if (tx_ready) state_d = StTxB2;
            end
            StTxB2: begin
                if (req) pending_d = 1'b1;
                if (tx_ready) begin
                    // A request landing on the final handshake starts the next report
                    if (pending_q || req) begin
                        start     = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = StTxIdle;
                    end
                end
            end
            default: state_d = StTxIdle;
        endcase
        if (start) begin
            state_d = StTxB1;
            // pk numbers bits MSB-first, so indicators[0:5] is the top six bits
            b1_d    = {RPT_HDR_B1, indicators[9:4]};
            b2_d    = {RPT_HDR_B2, rotary_pos, 2'b00};
        end
    end

    always_comb begin
        tx_valid = (state_q != StTxIdle);
        tx_data  = '0;
        if (state_q == StTxB1) tx_data = b1_q;
        if (state_q == StTxB2) tx_data = b2_q;
    end

endmodule

// File: rtl/pk_link.sv
// Host link top: decodes UART command bytes into pk IOBUS strobes and reports
// panel state back. Optional PK_LINK_AUTOREPORT_EN sends a report on any change.
module pk_link
    import pk_link_pkg::*;
#(
    parameter int unsigned CLK_SYS_HZ      = 50_000_000,
    parameter int unsigned KEYS_TIMEOUT_MS = 10
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    pk_link_if.slave    uart,
    input  logic [9:0]  indicators,
    input  logic [3:0]  rotary_pos,
    output logic [3:0]  fn,
    output logic        fn_v,
    output logic        fn_trig,
    output logic [3:0]  rotary_in,
    output logic        rotary_trig,
    output logic [15:0] keys,
    output logic        keys_trig,
    output logic        cmd_err
);

    localparam int unsigned TimeoutCycles = KEYS_TIMEOUT_MS * CLK_SYS_HZ / 1000;
    localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoReload = TmoW'(TimeoutCycles - 1);

    rx_state_e       state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      key_hi_q, key_hi_d;
    logic [3:0]      fn_q, fn_d, rot_q, rot_d;
    logic            fn_v_q, fn_v_d;
    logic [15:0]     keys_q, keys_d;
    logic            fn_trig_q, fn_trig_d, rot_trig_q, rot_trig_d;
    logic            keys_trig_q, keys_trig_d, err_q, err_d;
    logic            status_req, auto_req;
    logic [7:0]      rx;

    assign rx = uart.rx_data;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            key_hi_q    <= '0;
            fn_q        <= '0;
            fn_v_q      <= 1'b0;
            rot_q       <= '0;
            keys_q      <= '0;
            fn_trig_q   <= 1'b0;
            rot_trig_q  <= 1'b0;
            keys_trig_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            key_hi_q    <= key_hi_d;
            fn_q        <= fn_d;
            fn_v_q      <= fn_v_d;
            rot_q       <= rot_d;
            keys_q      <= keys_d;
            fn_trig_q   <= fn_trig_d;
            rot_trig_q  <= rot_trig_d;
            keys_trig_q <= keys_trig_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        key_hi_d    = key_hi_q;
        fn_d        = fn_q;
        fn_v_d      = fn_v_q;
        rot_d       = rot_q;
        keys_d      = keys_q;
        fn_trig_d   = 1'b0;
        rot_trig_d  = 1'b0;
        keys_trig_d = 1'b0;
        err_d       = 1'b0;
        status_req  = 1'b0;
        case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (uart.rx_valid) begin
                    if (rx[7:5] == CMD_FN[7:5]) begin
                        if (rx[3:0] < FN_LIMIT) begin
                            fn_d      = rx[3:0];
                            fn_v_d    = rx[4];
                            fn_trig_d = 1'b1;
                        end
                    end else if (rx[7:4] == CMD_ROT[7:4]) begin
                        rot_d      = rx[3:0];
                        rot_trig_d = 1'b1;
                    end else if (rx == CMD_KEYS) begin
                        state_d = StKeyHi;
                        tmo_d   = TmoReload;
                    end else if (rx == CMD_STATUS) begin
                        status_req = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StKeyHi, StKeyLo: begin
                if (uart.rx_valid) begin
                    tmo_d = TmoReload;
                    if (state_q == StKeyHi) begin
                        key_hi_d = rx;
                        state_d  = StKeyLo;
                    end else begin
                        keys_d      = {key_hi_q, rx};
                        keys_trig_d = 1'b1;
                        state_d     = StIdle;
                        tmo_d       = '0;
                    end
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef PK_LINK_AUTOREPORT_EN
    logic [9:0] ind_prev_q;
    logic [3:0] rot_prev_q;
    logic       first_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ind_prev_q <= '0;
            rot_prev_q <= '0;
            first_q    <= 1'b1;
        end else begin
            ind_prev_q <= indicators;
            rot_prev_q <= rotary_pos;
            first_q    <= 1'b0;
        end
    end

    assign auto_req = first_q | (ind_prev_q != indicators) | (rot_prev_q != rotary_pos);
`else
    assign auto_req = 1'b0;
`endif

    pk_link_tx u_tx (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .req        (status_req | auto_req),
        .indicators (indicators),
        .rotary_pos (rotary_pos),
        .tx_ready   (uart.tx_ready),
        .tx_data    (uart.tx_data),
        .tx_valid   (uart.tx_valid)
    );

    assign fn          = fn_q;
    assign fn_v        = fn_v_q;
    assign fn_trig     = fn_trig_q;
    assign rotary_in   = rot_q;
    assign rotary_trig = rot_trig_q;
    assign keys        = keys_q;
    assign keys_trig   = keys_trig_q;
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_pk_link.sv
// Self-checking bench for pk_link: single-byte command table, KEYS sequences,
// timeout, report back-pressure/collapse and reset abort.
module tb_pk_link;

    localparam int unsigned ClkHz     = 10_000;
    localparam int unsigned TmoMs     = 10;
    localparam int unsigned TmoCycles = TmoMs * ClkHz / 1000;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [9:0]  indicators = 10'h3ff;
    logic [3:0]  rotary_pos = 4'd5;
    logic [3:0]  fn, rotary_in;
    logic        fn_v, fn_trig, rotary_trig, keys_trig, cmd_err;
    logic [15:0] keys;

    pk_link_if bus ();

    pk_link #(.CLK_SYS_HZ(ClkHz), .KEYS_TIMEOUT_MS(TmoMs)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .uart        (bus.slave),
        .indicators  (indicators),
        .rotary_pos  (rotary_pos),
        .fn          (fn),
        .fn_v        (fn_v),
        .fn_trig     (fn_trig),
        .rotary_in   (rotary_in),
        .rotary_trig (rotary_trig),
        .keys        (keys),
        .keys_trig   (keys_trig),
        .cmd_err     (cmd_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    // {fn_trig, fn, fn_v, rotary_trig, rotary_in, keys_trig, cmd_err}
    typedef struct packed {
        logic [7:0]  rx;
        logic [12:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] rx, input logic ft, input logic [3:0] f,
                                input logic fv, input logic rt, input logic [3:0] r,
                                input logic e);
        mk.rx  = rx;
        mk.exp = {ft, f, fv, rt, r, 1'b0, e};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk_sys);
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_report();
        exp_q.push_back(8'hff);
        exp_q.push_back(8'h94);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk_sys);
        check("reset_outputs", 64'({fn, fn_v, fn_trig, rotary_in, rotary_trig, keys, keys_trig,
                                    cmd_err, bus.tx_data, bus.tx_valid}), 64'd0);
        exp_q.delete();
`ifdef PK_LINK_AUTOREPORT_EN
        push_report();
`endif
        @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk_sys);
            if (exp_q.size() == 0 && !bus.tx_valid) done = 1'b1;
        end
        check(name, 64'({exp_q.size() != 0, bus.tx_valid}), 64'd0);
    endtask

    // Scoreboard: every transfer pops the next expected byte; stalls must hold it
    initial begin
        forever begin
            @(negedge clk_sys);
            #1;
            if (rst_n && bus.tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got byte %02h, expected no transfer",
                             bus.tx_data);
                end else if (bus.tx_ready) begin
                    check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
                end else begin
                    check("tx_stall_hold", 64'(bus.tx_data), 64'(exp_q[0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        int   k;

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;

        vecs[0]  = mk(8'h10, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[1]  = mk(8'h0c, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[2]  = mk(8'h05, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0);
        vecs[3]  = mk(8'h1b, 1'b1, 4'hb, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[4]  = mk(8'h1f, 1'b0, 4'hb, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[5]  = mk(8'h2a, 1'b0, 4'hb, 1'b1, 1'b1, 4'ha, 1'b0);
        vecs[6]  = mk(8'h20, 1'b0, 4'hb, 1'b1, 1'b1, 4'h0, 1'b0);
        vecs[7]  = mk(8'h45, 1'b0, 4'hb, 1'b1, 1'b0, 4'h0, 1'b1);
        vecs[8]  = mk(8'h32, 1'b0, 4'hb, 1'b1, 1'b0, 4'h0, 1'b1);
        vecs[9]  = mk(8'hff, 1'b0, 4'hb, 1'b1, 1'b0, 4'h0, 1'b1);
        vecs[10] = mk(8'h11, 1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[11] = mk(8'h2f, 1'b0, 4'h1, 1'b1, 1'b1, 4'hf, 1'b0);

        do_reset();
        wait_drain("initial_report_drain");

        foreach (vecs[i]) begin
            send_byte(vecs[i].rx);
            check($sformatf("cmd_%02h", vecs[i].rx),
                  64'({fn_trig, fn, fn_v, rotary_trig, rotary_in, keys_trig, cmd_err}),
                  64'(vecs[i].exp));
            @(negedge clk_sys);
            check("strobe_width", 64'({fn_trig, rotary_trig, keys_trig, cmd_err}), 64'd0);
        end

        // KEYS back-to-back: one strobe only after the low byte
        @(negedge clk_sys);
        bus.rx_data = 8'h30; bus.rx_valid = 1'b1;
        @(negedge clk_sys);
        bus.rx_data = 8'hbe;
        check("keys_early_0", 64'({keys_trig, cmd_err, keys}), 64'd0);
        @(negedge clk_sys);
        bus.rx_data = 8'hef;
        check("keys_early_1", 64'({keys_trig, cmd_err, keys}), 64'd0);
        @(negedge clk_sys);
        bus.rx_valid = 1'b0;
        check("keys_done", 64'({keys_trig, cmd_err, keys}), 64'({2'b10, 16'hbeef}));
        @(negedge clk_sys);
        check("keys_width", 64'(keys_trig), 64'd0);

        // KEYS timeout after the high byte
        send_byte(8'h30);
        send_byte(8'h12);
        k = 0;
        while (!cmd_err && k < 3 * TmoCycles) begin
            @(negedge clk_sys);
            k++;
            if (keys_trig) check("tmo_no_keys_trig", 64'(keys_trig), 64'd0);
        end
        check("tmo_latency", 64'(k), 64'(TmoCycles));
        check("tmo_keys_kept", 64'({cmd_err, keys}), 64'({1'b1, 16'hbeef}));
        send_byte(8'h21);
        check("tmo_then_rot", 64'({rotary_trig, rotary_in, cmd_err}), 64'({1'b1, 4'h1, 1'b0}));

        // STATUS under back-pressure with collapsing follow-up requests
        @(negedge clk_sys);
        bus.tx_ready = 1'b0;
        push_report();
        send_byte(8'h31);
        check("tx_latency", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, 8'hff}));
        push_report();
        repeat (3) send_byte(8'h31);
        repeat (12) @(negedge clk_sys);
        bus.tx_ready = 1'b1;
        wait_drain("stall_drain");

        // Gapless bytes and a request coinciding with the final handshake
        push_report();
        push_report();
        send_byte(8'h31);
        check("b2b_b1", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, 8'hff}));
        @(negedge clk_sys);
        check("b2b_b2", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, 8'h94}));
        bus.rx_data = 8'h31; bus.rx_valid = 1'b1;
        @(negedge clk_sys);
        bus.rx_valid = 1'b0;
        check("b2b_restart", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, 8'hff}));
        wait_drain("b2b_drain");

        // Reset between KEYS data bytes aborts the command
        send_byte(8'h30);
        send_byte(8'hbe);
        do_reset();
        send_byte(8'hef);
        check("reset_abort", 64'({keys_trig, keys, cmd_err}), 64'({1'b0, 16'h0, 1'b1}));
        wait_drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
